// File: rtl/lcd_scanout_buf.sv
// Frame buffer with one or two banks: a ce-qualified pixel writer fills a bank
// while an independent h/v scan reads the other through a two-tick pipeline.
module lcd_scanout_buf #(
  parameter int unsigned      WIDTH        = 160,
  parameter int unsigned      HEIGHT       = 144,
  parameter int unsigned      PIX_W        = 15,
  parameter int unsigned      DOUBLE_BUF   = 1,
  parameter int unsigned      H_TOTAL      = 456,
  parameter int unsigned      V_TOTAL      = 154,
  parameter int unsigned      H_START      = 0,
  parameter int unsigned      V_START      = 0,
  parameter int unsigned      HS_START     = 200,
  parameter int unsigned      HS_LEN       = 32,
  parameter int unsigned      VS_START     = 148,
  parameter int unsigned      VS_LEN       = 3,
  parameter logic [PIX_W-1:0] BORDER_COLOR = '0
) (
  input  logic             clk_sys,
  input  logic             reset,
  input  logic             ce,
  input  logic             wr_en,
  input  logic [PIX_W-1:0] wr_data,
  input  logic             wr_frame_start,
  input  logic             freeze,
  input  logic             ce_pix,
  output logic [8:0]       h_cnt,
  output logic [8:0]       v_cnt,
  output logic             hs,
  output logic             vs,
  output logic             hbl,
  output logic             vbl,
  output logic [PIX_W-1:0] pix_out,
  output logic             wr_bank,
  output logic             rd_bank,
  output logic             frame_ready,
  output logic             frame_drop
);

  localparam int unsigned NPIX  = WIDTH * HEIGHT;
  localparam int unsigned PW    = $clog2(NPIX + 1);
  localparam int unsigned AW    = $clog2(NPIX);
  localparam int unsigned BANKS = DOUBLE_BUF + 1;
  localparam bit          DBL   = (DOUBLE_BUF != 0);

  // First index is the bank, second the pointer: the {bank, ptr} space.
  logic [PIX_W-1:0] mem_q [BANKS][NPIX];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d, wr_addr;
  logic          wr_start, wr_do;
  logic          frame_ready_q, frame_ready_d;
  logic          frame_drop_q, frame_drop_d;
  logic          wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
  logic [8:0]    h_q, h_d, v_q, v_d;
  logic          line_wrap, frame_wrap;

  always_comb begin
    wr_start      = ce & wr_frame_start;
    wr_addr       = wr_start ? '0 : wr_ptr_q;
    wr_do         = ce & wr_en & ~freeze & ~frame_ready_q & (32'(wr_addr) < NPIX);
    wr_ptr_d      = wr_addr + PW'(wr_do);
    frame_drop_d  = wr_start & frame_ready_q;

    line_wrap  = ce_pix & (h_q == 9'(H_TOTAL - 1));
    frame_wrap = line_wrap & (v_q == 9'(V_TOTAL - 1));
    h_d = h_q;
    v_d = v_q;
    if (ce_pix)    h_d = line_wrap ? '0 : h_q + 9'd1;
    if (line_wrap) v_d = frame_wrap ? '0 : v_q + 9'd1;

    frame_ready_d = frame_ready_q;
    wr_bank_d     = wr_bank_q;
    rd_bank_d     = rd_bank_q;
    if (wr_do && (32'(wr_addr) == NPIX - 1)) frame_ready_d = 1'b1;
    // Registered flag only: a frame completing on the wrap edge waits a frame.
    if (frame_wrap && frame_ready_q) begin
      frame_ready_d = 1'b0;
      if (DBL) begin
        rd_bank_d = wr_bank_q;
        wr_bank_d = ~wr_bank_q;
      end
    end
  end

  logic [31:0]   hx, vy;
  logic          act_h, act_v, act_d, hs_d, vs_d;
  logic [AW-1:0] rd_ptr_d;

  always_comb begin
    hx       = 32'(h_q) - H_START;
    vy       = 32'(v_q) - V_START;
    act_h    = hx < WIDTH;
    act_v    = vy < HEIGHT;
    act_d    = act_h & act_v;
    rd_ptr_d = act_d ? AW'(vy * WIDTH + hx) : '0;
    hs_d     = (32'(h_q) - HS_START) < HS_LEN;
    vs_d     = (32'(v_q) - VS_START) < VS_LEN;
  end

  logic             act1_q, hs1_q, vs1_q, hbl1_q, vbl1_q;
  logic [AW-1:0]    rd_ptr1_q;
  logic             hs2_q, vs2_q, hbl2_q, vbl2_q;
  logic [PIX_W-1:0] pix2_q;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      wr_ptr_q      <= '0;
      frame_ready_q <= 1'b0;
      frame_drop_q  <= 1'b0;
      wr_bank_q     <= 1'b0;
      rd_bank_q     <= DBL;
      h_q           <= '0;
      v_q           <= '0;
      act1_q        <= 1'b0;
      hs1_q         <= 1'b0;
      vs1_q         <= 1'b0;
      hbl1_q        <= 1'b1;
      vbl1_q        <= 1'b1;
      rd_ptr1_q     <= '0;
      hs2_q         <= 1'b0;
      vs2_q         <= 1'b0;
      hbl2_q        <= 1'b1;
      vbl2_q        <= 1'b1;
      pix2_q        <= '0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      frame_ready_q <= frame_ready_d;
      frame_drop_q  <= frame_drop_d;
      wr_bank_q     <= wr_bank_d;
      rd_bank_q     <= rd_bank_d;
      h_q           <= h_d;
      v_q           <= v_d;
      if (ce_pix) begin
        act1_q    <= act_d;
        hs1_q     <= hs_d;
        vs1_q     <= vs_d;
        hbl1_q    <= ~act_h;
        vbl1_q    <= ~act_v;
        rd_ptr1_q <= rd_ptr_d;
        pix2_q    <= act1_q ? mem_q[rd_bank_q][rd_ptr1_q] : BORDER_COLOR;
        hs2_q     <= hs1_q;
        vs2_q     <= vs1_q;
        hbl2_q    <= hbl1_q;
        vbl2_q    <= vbl1_q;
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (wr_do && !reset) mem_q[wr_bank_q][wr_addr[AW-1:0]] <= wr_data;
  end

  assign h_cnt       = h_q;
  assign v_cnt       = v_q;
  assign hs          = hs2_q;
  assign vs          = vs2_q;
  assign hbl         = hbl2_q;
  assign vbl         = vbl2_q;
  assign pix_out     = pix2_q;
  assign wr_bank     = wr_bank_q;
  assign rd_bank     = rd_bank_q;
  assign frame_ready = frame_ready_q;
  assign frame_drop  = frame_drop_q;

endmodule

// File: tb/tb_lcd_scanout_buf.sv
// Bench for lcd_scanout_buf on a reduced raster: directed buffer scenarios plus
// random traffic, compared each cycle with a frame-level reference model.
module tb_lcd_scanout_buf;
  timeunit 1ns;
  timeprecision 1ps;

  localparam int unsigned W = 16, H = 8, HT = 24, VT = 12;
  localparam int unsigned HS0 = 3, VS0 = 2, HSS = 20, HSL = 2, VSS = 11, VSL = 1;
  localparam logic [14:0] BORDER = 15'h1234;
  localparam int unsigned NPIX = W * H, FRAME = HT * VT;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1, ce = 1'b0, wr_en = 1'b0, wr_frame_start = 1'b0;
  logic        freeze = 1'b0, ce_pix = 1'b0;
  logic [14:0] wr_data = '0;
  logic [8:0]  h_cnt, v_cnt;
  logic        hs, vs, hbl, vbl, wr_bank, rd_bank, frame_ready, frame_drop;
  logic [14:0] pix_out;

  lcd_scanout_buf #(
    .WIDTH(W), .HEIGHT(H), .PIX_W(15), .DOUBLE_BUF(1),
    .H_TOTAL(HT), .V_TOTAL(VT), .H_START(HS0), .V_START(VS0),
    .HS_START(HSS), .HS_LEN(HSL), .VS_START(VSS), .VS_LEN(VSL),
    .BORDER_COLOR(BORDER)
  ) dut (
    .clk_sys(clk), .reset(reset), .ce(ce), .wr_en(wr_en), .wr_data(wr_data),
    .wr_frame_start(wr_frame_start), .freeze(freeze), .ce_pix(ce_pix),
    .h_cnt(h_cnt), .v_cnt(v_cnt), .hs(hs), .vs(vs), .hbl(hbl), .vbl(vbl),
    .pix_out(pix_out), .wr_bank(wr_bank), .rd_bank(rd_bank),
    .frame_ready(frame_ready), .frame_drop(frame_drop)
  );

  int unsigned n_checks = 0, n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    logic [14:0] pix;
    bit          known;
    bit          hs;
    bit          vs;
    bit          hbl;
    bit          vbl;
  } view_t;

  int unsigned m_h, m_v, m_ptr;
  bit          m_ready, m_drop, m_wbank, m_rbank;
  logic [14:0] m_mem   [2][NPIX];
  bit          m_known [2][NPIX];
  view_t       m_pipe[$];
  view_t       m_out;

  function automatic int unsigned pos();
    return m_v * HT + m_h;
  endfunction

  task automatic model_step(input bit rst, input bit c, input bit we, input logic [14:0] d,
                            input bit fs, input bit frz, input bit cep);
    view_t       e;
    int unsigned addr;
    bit          wr, wrap, nxt_ready;
    if (rst) begin
      m_h = 0; m_v = 0; m_ptr = 0; m_ready = 0; m_drop = 0; m_wbank = 0; m_rbank = 1;
      m_out = '{pix: '0, known: 1'b1, hs: 1'b0, vs: 1'b0, hbl: 1'b1, vbl: 1'b1};
      m_pipe.delete();
      m_pipe.push_back('{pix: BORDER, known: 1'b1, hs: 1'b0, vs: 1'b0, hbl: 1'b1, vbl: 1'b1});
      return;
    end
    addr = (c && fs) ? 0 : m_ptr;
    wr   = c && we && !frz && !m_ready && (addr < NPIX);
    wrap = cep && (m_h == HT - 1) && (m_v == VT - 1);
    if (cep) begin
      e.hs  = (m_h >= HSS) && (m_h < HSS + HSL);
      e.vs  = (m_v >= VSS) && (m_v < VSS + VSL);
      e.hbl = !((m_h >= HS0) && (m_h < HS0 + W));
      e.vbl = !((m_v >= VS0) && (m_v < VS0 + H));
      if (!e.hbl && !e.vbl) begin
        e.pix   = m_mem[m_rbank][(m_v - VS0) * W + (m_h - HS0)];
        e.known = m_known[m_rbank][(m_v - VS0) * W + (m_h - HS0)];
      end else begin
        e.pix   = BORDER;
        e.known = 1'b1;
      end
      m_pipe.push_back(e);
      m_out = m_pipe.pop_front();
      if (m_h == HT - 1) begin
        m_h = 0;
        m_v = (m_v == VT - 1) ? 0 : m_v + 1;
      end else m_h++;
    end
    if (wr) begin
      m_mem[m_wbank][addr]   = d;
      m_known[m_wbank][addr] = 1'b1;
    end
    m_drop    = c && fs && m_ready;
    nxt_ready = m_ready;
    if (wr && addr == NPIX - 1) nxt_ready = 1'b1;
    if (wrap && m_ready) begin
      m_rbank   = m_wbank;
      m_wbank   = !m_wbank;
      nxt_ready = 1'b0;
    end
    m_ready = nxt_ready;
    m_ptr   = addr + (wr ? 1 : 0);
  endtask

  task automatic compare_all();
    check("h_cnt", h_cnt, m_h);
    check("v_cnt", v_cnt, m_v);
    check("hs", hs, m_out.hs);
    check("vs", vs, m_out.vs);
    check("hbl", hbl, m_out.hbl);
    check("vbl", vbl, m_out.vbl);
    if (m_out.known) check("pix_out", pix_out, m_out.pix);
    check("frame_ready", frame_ready, m_ready);
    check("frame_drop", frame_drop, m_drop);
    check("wr_bank", wr_bank, m_wbank);
    check("rd_bank", rd_bank, m_rbank);
  endtask

  task automatic cycle(input bit rst, input bit c, input bit we, input logic [14:0] d,
                       input bit fs, input bit frz, input bit cep);
    @(negedge clk);
    reset = rst; ce = c; wr_en = we; wr_data = d; wr_frame_start = fs; freeze = frz; ce_pix = cep;
    model_step(rst, c, we, d, fs, frz, cep);
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_h"}, h_cnt, 0);
    check({tag, "_v"}, v_cnt, 0);
    check({tag, "_ready"}, frame_ready, 0);
    check({tag, "_drop"}, frame_drop, 0);
    check({tag, "_wbank"}, wr_bank, 0);
    check({tag, "_rbank"}, rd_bank, 1);
  endtask

  logic [14:0] d20;

  initial begin
    // Reset, with other inputs toggling to show reset wins.
    repeat (3) cycle(1, 1'($urandom), 1'($urandom), 15'($urandom), 1'($urandom), 1'b0, 1'($urandom));
    check_reset_state("rst");
    check("rst_hs", hs, 0);
    check("rst_vs", vs, 0);
    check("rst_hbl", hbl, 1);
    check("rst_vbl", vbl, 1);
    check("rst_pix", pix_out, 0);

    // Full frame, data = index, then swap at the frame wrap and read back.
    for (int unsigned i = 0; i < NPIX; i++) cycle(0, 1, 1, 15'(i), i == 0, 0, 1);
    check("B_ready", frame_ready, 1);
    repeat (FRAME - NPIX) cycle(0, 0, 0, '0, 0, 0, 1);
    check("B_rd_bank", rd_bank, 0);
    check("B_wr_bank", wr_bank, 1);
    check("B_ready_clr", frame_ready, 0);
    for (int unsigned i = 0; i < FRAME; i++) begin
      cycle(0, 0, 0, '0, 0, 0, 1);
      if (m_h == HS0 + 7 && m_v == VS0 + 2) check("B_pix_5_2", pix_out, 37);
    end

    // Frame completes on the very edge of the frame wrap: swap deferred one frame.
    repeat ((2 * FRAME - NPIX - pos()) % FRAME) cycle(0, 0, 0, '0, 0, 0, 1);
    for (int unsigned i = 0; i < NPIX; i++) cycle(0, 1, 1, 15'($urandom), i == 0, 0, 1);
    check("C_ready", frame_ready, 1);
    check("C_no_swap_rd", rd_bank, 0);
    check("C_no_swap_wr", wr_bank, 1);
    repeat (FRAME) cycle(0, 0, 0, '0, 0, 0, 1);
    check("C_swap_rd", rd_bank, 1);
    check("C_swap_wr", wr_bank, 0);
    check("C_ready_clr", frame_ready, 0);

    // Drop: write while ready is discarded, frame start pulses frame_drop.
    for (int unsigned i = 0; i < NPIX; i++) cycle(0, 1, 1, 15'($urandom), i == 0, 0, 0);
    check("D_ready", frame_ready, 1);
    cycle(0, 1, 1, 15'h7FFF, 0, 0, 0);
    cycle(0, 1, 0, '0, 1, 0, 0);
    check("D_drop", frame_drop, 1);
    cycle(0, 0, 0, '0, 0, 0, 0);
    check("D_drop_end", frame_drop, 0);
    repeat (FRAME) cycle(0, 0, 0, '0, 0, 0, 1);
    check("D_swap_rd", rd_bank, 0);
    check("D_swap_wr", wr_bank, 1);

    // Pointer was reset by the dropped start; freeze holds it for 10 strobes.
    cycle(0, 1, 1, 15'h2AAA, 0, 0, 0);
    for (int unsigned i = 1; i < 20; i++) cycle(0, 1, 1, 15'($urandom), 0, 0, 0);
    repeat (10) cycle(0, 1, 1, 15'h5555, 0, 1, 0);
    d20 = 15'($urandom) & 15'h3FFF;
    cycle(0, 1, 1, d20, 0, 0, 0);
    for (int unsigned i = 21; i < NPIX - 1; i++) cycle(0, 1, 1, 15'($urandom), 0, 0, 0);
    check("E_not_ready", frame_ready, 0);
    cycle(0, 1, 1, 15'($urandom), 0, 0, 0);
    check("E_ready", frame_ready, 1);
    repeat (FRAME) cycle(0, 0, 0, '0, 0, 0, 1);
    check("E_swap_rd", rd_bank, 1);
    for (int unsigned i = 0; i < FRAME; i++) begin
      cycle(0, 0, 0, '0, 0, 0, 1);
      if (m_h == HS0 + 2 && m_v == VS0) check("E_pix_addr0", pix_out, 15'h2AAA);
      if (m_h == HS0 + 6 && m_v == VS0 + 1) check("E_pix_addr20", pix_out, d20);
    end

    // Random traffic on every input.
    repeat (3000)
      cycle(($urandom % 1500) == 0, ($urandom % 4) != 0, ($urandom % 4) != 0, 15'($urandom),
            ($urandom % 300) == 0, ($urandom % 16) == 0, ($urandom % 4) != 0);

    // Reset mid-frame with a partial frame in progress, then a clean frame.
    repeat (2) cycle(1, 0, 0, '0, 0, 0, 0);
    for (int unsigned i = 0; i < 50; i++) cycle(0, 1, 1, 15'($urandom), i == 0, 0, 1);
    for (int unsigned k = 0; k < FRAME && m_v != VT / 2; k++) cycle(0, 0, 0, '0, 0, 0, 1);
    check("G_at_mid", v_cnt, VT / 2);
    cycle(1, 1, 1, 15'($urandom), 1, 0, 1);
    check_reset_state("G_rst");
    for (int unsigned i = 0; i < NPIX; i++) cycle(0, 1, 1, 15'($urandom), i == 0, 0, 1);
    repeat (FRAME - NPIX) cycle(0, 0, 0, '0, 0, 0, 1);
    check("G_swap_rd", rd_bank, 0);
    check("G_swap_wr", wr_bank, 1);
    repeat (FRAME) cycle(0, 0, 0, '0, 0, 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
